// File: rtl/decode_stage.sv
// decode_stage
//   Instruction decode stage with a two-entry (output + skid) elastic buffer.
//   An accepted instruction is decoded combinationally and registered, so every
//   payload output comes straight from a flop. in_ready depends only on the
//   skid register, which breaks any combinational path from out_ready upstream.
//
// Parameters
//   XLEN     datapath width (32 or 64); immediate and PC are XLEN wide
//   EN_JUMP  1: JAL/JALR/LUI/AUIPC are legal; 0: they decode as illegal
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous discard of both held instructions
//   in_valid/in_ready          upstream handshake, in_inst/in_pc payload
//   out_valid/out_ready        downstream handshake, out_pc of presented instr
//   write_en..illegal_inst     registered decode results, meaningful while out_valid=1
module decode_stage #(
   parameter int XLEN    = 32,
   parameter bit EN_JUMP = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic            write_en,
   output logic [4:0]      write_addr,
   output logic [4:0]      read_addr1,
   output logic [4:0]      read_addr2,
   output logic [XLEN-1:0] immediate,
   output logic            mem_write_en,
   output logic            mem_read_en,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [3:0]      alu_opcode,
   output logic            i_type_inst,
   output logic            branch_inst,
   output logic            jump_inst,
   output logic            illegal_inst
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            we;
      logic [4:0]      wa;
      logic [4:0]      ra1;
      logic [4:0]      ra2;
      logic [XLEN-1:0] imm;
      logic            mwe;
      logic            mre;
      logic [2:0]      f3;
      logic [6:0]      f7;
      logic [3:0]      alu;
      logic            it;
      logic            br;
      logic            jp;
      logic            ill;
   } payload_t;

   // Widen a 32-bit signed immediate to XLEN; the cast keeps signedness, so it sign-extends.
   function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
      return XLEN'(v);
   endfunction

   logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   payload_t           dec_d;
   logic [6:0]         opc;

   // Each immediate is packed into the top of a 32-bit word and arithmetically
   // shifted down, which sign-extends from inst[31] in one step.
   assign opc   = in_inst[6:0];
   assign imm_i = $signed(in_inst) >>> 20;
   assign imm_s = $signed({in_inst[31:25], in_inst[11:7], 20'h0}) >>> 20;
   assign imm_b = $signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0, 19'h0}) >>> 19;
   assign imm_u = $signed({in_inst[31:12], 12'h0});
   assign imm_j = $signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0, 11'h0}) >>> 11;

   always_comb begin
      dec_d     = '0;
      dec_d.pc  = in_pc;
      dec_d.wa  = in_inst[11:7];
      dec_d.ra1 = in_inst[19:15];
      dec_d.ra2 = in_inst[24:20];
      dec_d.f3  = in_inst[14:12];
      dec_d.f7  = in_inst[31:25];
      case (opc)
         7'b0010011: begin
            dec_d.we  = 1'b1;
            dec_d.it  = 1'b1;
            dec_d.imm = sext(imm_i);
            // Only the shift-right group uses inst[30] (SRLI/SRAI); for ADDI etc. it is immediate data.
            dec_d.alu = (in_inst[14:12] == 3'b101) ? {in_inst[30], 3'b101} : {1'b0, in_inst[14:12]};
         end
         7'b0110011: begin
            dec_d.we  = 1'b1;
            dec_d.alu = {in_inst[30], in_inst[14:12]};
         end
         7'b1100011: begin
            dec_d.br  = 1'b1;
            dec_d.imm = sext(imm_b);
         end
         7'b0000011: begin
            dec_d.we  = 1'b1;
            dec_d.mre = 1'b1;
            dec_d.it  = 1'b1;
            dec_d.imm = sext(imm_i);
         end
         7'b0100011: begin
            dec_d.mwe = 1'b1;
            dec_d.it  = 1'b1;
            dec_d.imm = sext(imm_s);
         end
         7'b0110111, 7'b0010111: begin
            if (EN_JUMP) begin
               dec_d.we  = 1'b1;
               dec_d.it  = 1'b1;
               dec_d.imm = sext(imm_u);
            end else begin
               dec_d.ill = 1'b1;
            end
         end
         7'b1101111, 7'b1100111: begin
            if (EN_JUMP) begin
               dec_d.we  = 1'b1;
               dec_d.jp  = 1'b1;
               dec_d.it  = 1'b1;
               dec_d.imm = (opc == 7'b1101111) ? sext(imm_j) : sext(imm_i);
            end else begin
               dec_d.ill = 1'b1;
            end
         end
         default: dec_d.ill = 1'b1;
      endcase
      // x0 is hardwired to zero, so a write to it is dropped here rather than downstream.
      if (dec_d.wa == 5'd0) dec_d.we = 1'b0;
   end

   logic     out_valid_q, out_valid_d;
   logic     skid_valid_q, skid_valid_d;
   payload_t out_q, out_d, skid_q;
   logic     load_out, load_skid;

   assign in_ready = ~skid_valid_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      load_out     = 1'b0;
      load_skid    = 1'b0;
      out_d        = dec_d;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // Skid full implies output full and in_ready low: only a drain can happen.
         if (out_ready) begin
            load_out     = 1'b1;
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (in_valid) begin
         if (!out_valid_q || out_ready) begin
            load_out    = 1'b1;
            out_valid_d = 1'b1;
         end else begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q        <= '0;
         skid_q       <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         if (load_out)  out_q  <= out_d;
         if (load_skid) skid_q <= dec_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_pc       = out_q.pc;
   assign write_en     = out_q.we;
   assign write_addr   = out_q.wa;
   assign read_addr1   = out_q.ra1;
   assign read_addr2   = out_q.ra2;
   assign immediate    = out_q.imm;
   assign mem_write_en = out_q.mwe;
   assign mem_read_en  = out_q.mre;
   assign funct3       = out_q.f3;
   assign funct7       = out_q.f7;
   assign alu_opcode   = out_q.alu;
   assign i_type_inst  = out_q.it;
   assign branch_inst  = out_q.br;
   assign jump_inst    = out_q.jp;
   assign illegal_inst = out_q.ill;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width; legal values 32 and 64; immediate and PC are XLEN wide.
REQ-002 Parameter EN_JUMP, 1, when 1 JAL/JALR/LUI/AUIPC decode legally; when 0 they are flagged illegal.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port flush  input  1  synchronous discard of all held instructions.
REQ-006 Port in_valid / in_ready  input / output  1 / 1  upstream handshake; transfer when both are high.
REQ-007 Port in_inst / in_pc  input  32 / XLEN  instruction word and its PC.
REQ-008 Port out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-009 Port out_pc  output  XLEN  PC of the presented instruction.
REQ-010 Ports write_en 1, write_addr 5, read_addr1 5, read_addr2 5, immediate XLEN, mem_write_en 1, mem_read_en 1, funct3 3, funct7 7, alu_opcode 4, i_type_inst 1, branch_inst 1, jump_inst 1, illegal_inst 1; all outputs, registered, valid only while out_valid=1.

Function
REQ-011 Field extraction: opcode=inst[6:0], funct3=inst[14:12], funct7=inst[31:25], write_addr=inst[11:7], read_addr1=inst[19:15], read_addr2=inst[24:20].
REQ-012 Immediates are sign-extended from inst[31] to XLEN: I={inst[31:20]}, S={inst[31:25],inst[11:7]}, B={inst[7],inst[30:25],inst[11:8],0}, U={inst[31:12],12'h0} sign-extended, J={inst[19:12],inst[20],inst[30:21],0}.
REQ-013 Opcode 0010011 (OP-IMM): write_en, i_type_inst, imm I; alu_opcode={inst[30],101} when funct3=101, else {0,funct3}.
REQ-014 Opcode 0110011 (OP): write_en; alu_opcode={inst[30],funct3}; immediate 0.
REQ-015 Opcode 1100011 (BRANCH): branch_inst, imm B, alu_opcode 0000.
REQ-016 Opcode 0000011 (LOAD): write_en, mem_read_en, i_type_inst, imm I, alu_opcode 0000.
REQ-017 Opcode 0100011 (STORE): mem_write_en, i_type_inst, imm S, alu_opcode 0000.
REQ-018 Opcodes 0110111 (LUI), 0010111 (AUIPC): write_en, i_type_inst, imm U, alu_opcode 0000.
REQ-019 Opcode 1101111 (JAL): write_en, jump_inst, i_type_inst, imm J; 1100111 (JALR): write_en, jump_inst, i_type_inst, imm I; alu_opcode 0000 for both.
REQ-020 Any other opcode, or REQ-018/019 opcodes with EN_JUMP=0: illegal_inst=1, write_en, mem_*_en, branch_inst, jump_inst, i_type_inst all 0, immediate 0, alu_opcode 0000.
REQ-021 write_en is forced to 0 whenever write_addr=0.
REQ-022 Immediate is 0 (never X) for opcodes without an immediate.
REQ-023 Storage: one output register (out_valid) plus one skid register (skid_valid); latency in_valid accept to out_valid is exactly 1 cycle when the output is empty or draining.
REQ-024 in_ready = ~skid_valid (registered-state only, no combinational path from out_ready).
REQ-025 Accept with output empty or out_ready=1 and skid empty: decoded word loads output register.
REQ-026 Accept while out_valid=1 and out_ready=0: decoded word loads skid register; in_ready falls next cycle.
REQ-027 Output consumed (out_valid & out_ready) with skid_valid=1: skid content moves to output register, skid_valid clears; a same-cycle accept is impossible (in_ready=0).
REQ-028 Order is strictly preserved; no instruction is dropped or duplicated except by flush/reset.
REQ-029 flush=1: out_valid and skid_valid clear next edge; an instruction accepted in the flush cycle is discarded; flush overrides all other updates.
REQ-030 Output payload holds its value while out_valid=1 and out_ready=0.

Reset
REQ-031 While rst_n=0: out_valid=0, skid_valid=0, in_ready=1, all payload outputs 0; takes effect asynchronously, release is synchronous to clk.
REQ-032 Reset mid-transfer discards both stored instructions.

Verification
REQ-033 in_inst=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, write_en=1, write_addr=1, immediate=5, alu_opcode=0000, i_type_inst=1.
REQ-034 in_inst=0x4020D193 (srai x3,x1,2) -> alu_opcode=1101, immediate=0x402; then 0x40208033 (sub x0,x1,x2) -> alu_opcode=1000, write_en=0.
REQ-035 out_ready=0 for 3 cycles, back-to-back inputs A,B,C -> A held on output, B in skid, in_ready=0, C stalled; out_ready=1 -> A,B,C delivered in order, no gap.
REQ-036 in_inst=0xFE000EE3 (beq, offset -4), XLEN=64 -> branch_inst=1, immediate=0xFFFF_FFFF_FFFF_FFFC; in_inst=0x0000006F with EN_JUMP=0 -> illegal_inst=1, write_en=0.
REQ-037 Output and skid both full, assert flush with in_valid=0 -> next cycle out_valid=0, in_ready=1; assert rst_n=0 mid-stream -> outputs 0 immediately, without a clock edge.
